// File: rtl/cbfp_blk_sequencer.sv
// ---------------------------------------------------------------------------
// cbfp_blk_sequencer
// Frame/block sequencer for the CBFP normalisation stage behind an FFT.
// It counts input beats into blocks and drives the magnitude and minimum
// units. Blocks are stored in a two-half ping-pong buffer. Each block is
// read back with shift_en once its minimum has resolved, and the read beats
// come out as valid_out tagged with their block index.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   start_i            frame start pulse (ignored while busy)
//   din_valid_i        input beat valid, no backpressure
//   busy_o             frame in progress
//   mag_en_o           magnitude-detect enable, one per accepted beat
//   min_en_o           min-compare enable (mag_en delayed one cycle)
//   min_clr_o          restart min compare, with min_en on beat 0
//   blk_last_o         with min_en on the last beat of a block
//   buf_wr_en_o        buffer write strobe (same as mag_en)
//   buf_wr_addr_o      {half, beat} write address
//   buf_rd_en_o        buffer read strobe
//   buf_rd_addr_o      {half, beat} read address
//   shift_en_o         apply block shift (same as buf_rd_en)
//   valid_out_o        normalised beat valid (read strobe + 1 cycle)
//   blk_idx_o          block index of the valid_out beat
//   frame_last_o       last valid_out beat of the frame
//   frame_done_o       one-cycle pulse after frame_last
//   ovf_err_o          sticky: din_valid seen while not accepting
// ---------------------------------------------------------------------------
module cbfp_blk_sequencer #(
  parameter int BEATS_PER_BLK = 4,
  parameter int NUM_BLK       = 8,
  parameter int RD_DELAY      = 2,
  localparam int AW = $clog2(2*BEATS_PER_BLK),
  localparam int BW = $clog2(BEATS_PER_BLK),
  localparam int IW = $clog2(NUM_BLK) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic          din_valid_i,
  output logic          busy_o,
  output logic          mag_en_o,
  output logic          min_en_o,
  output logic          min_clr_o,
  output logic          blk_last_o,
  output logic          buf_wr_en_o,
  output logic [AW-1:0] buf_wr_addr_o,
  output logic          buf_rd_en_o,
  output logic [AW-1:0] buf_rd_addr_o,
  output logic          shift_en_o,
  output logic          valid_out_o,
  output logic [IW-1:0] blk_idx_o,
  output logic          frame_last_o,
  output logic          frame_done_o,
  output logic          ovf_err_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RUN  = 1'b1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_BLK-1);

  logic [0:0]          state_q, state_d;
  logic [0:0]          rdState_q, rdState_d;
  logic [BW-1:0]       wrBeat_q, wrBeat_d;
  logic [IW-1:0]       wrBlk_q, wrBlk_d;
  logic                magEn_q, magEn_d;
  logic [AW-1:0]       wrAddr_q, wrAddr_d;
  logic                minEn_q, minEn_d;
  logic                minClr_q, minClr_d;
  logic                blkLast_q, blkLast_d;
  logic [RD_DELAY-1:0] tok_q, tok_d;
  logic [1:0]          pend_q, pend_d;
  logic [BW-1:0]       rdBeat_q, rdBeat_d;
  logic [IW-1:0]       rdBlk_q, rdBlk_d;
  logic                validOut_q, validOut_d;
  logic [IW-1:0]       blkIdx_q, blkIdx_d;
  logic                frameLast_q, frameLast_d;
  logic                frameDone_q, frameDone_d;
  logic                ovf_q, ovf_d;

  logic accept, startAcc, rdRun, rdLastBeat, tokExit, rdStart;

  // Shared decode. A read block starts when the reader is free (idle, or on
  // its final beat) and there is work: either a pending block or a token
  // leaving the delay line right now, so that back-to-back blocks chain with
  // no bubble and the first read lands exactly RD_DELAY after blk_last.
  always_comb begin
    accept     = (state_q == ST_RUN) && din_valid_i && (wrBlk_q < IW'(NUM_BLK));
    startAcc   = (state_q == ST_IDLE) && start_i;
    rdRun      = (rdState_q == RD_RUN);
    rdLastBeat = rdRun && (rdBeat_q == LAST_BEAT);
    tokExit    = tok_q[RD_DELAY-1];
    rdStart    = (!rdRun || rdLastBeat) && ((pend_q != 2'd0) || tokExit);
  end

  // Frame FSM plus the sticky overflow flag. A dropped beat wins over the
  // clear from start so that a beat arriving alongside start is still seen.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && start_i) state_d = ST_RUN;
    else if (state_q == ST_RUN && frameDone_q) state_d = ST_IDLE;
    ovf_d = startAcc ? 1'b0 : ovf_q;
    if (din_valid_i && !accept) ovf_d = 1'b1;
  end

  // Write side: beat/block counters advance only on accepted beats, and the
  // min-compare strobes follow the write strobe by one cycle. blkLast_d also
  // feeds the read delay line so token timing is anchored to blk_last.
  always_comb begin
    wrBeat_d = wrBeat_q;
    wrBlk_d  = wrBlk_q;
    wrAddr_d = wrAddr_q;
    if (startAcc) begin
      wrBeat_d = '0;
      wrBlk_d  = '0;
    end else if (accept) begin
      wrBeat_d = wrBeat_q + BW'(1);
      wrAddr_d = {wrBlk_q[0], wrBeat_q};
      if (wrBeat_q == LAST_BEAT) wrBlk_d = wrBlk_q + IW'(1);
    end
    magEn_d   = accept;
    minEn_d   = magEn_q;
    minClr_d  = magEn_q && (wrAddr_q[BW-1:0] == '0);
    blkLast_d = magEn_q && (wrAddr_q[BW-1:0] == LAST_BEAT);
  end

  // Token delay line and pending-block count. A token exiting in the same
  // cycle a read starts cancels out; pend saturates at the two buffer halves.
  always_comb begin
    tok_d[0] = blkLast_d;
    for (int i = 1; i < RD_DELAY; i++) tok_d[i] = tok_q[i-1];
    pend_d = pend_q;
    if (tokExit && !rdStart && pend_q != 2'd2) pend_d = pend_q + 2'd1;
    else if (!tokExit && rdStart) pend_d = pend_q - 2'd1;
  end

  // Read FSM. rdBlk advances at the end of every block so a restart from
  // idle already points at the next block; a new frame rewinds it.
  always_comb begin
    rdState_d = rdState_q;
    rdBeat_d  = rdBeat_q;
    rdBlk_d   = rdBlk_q;
    if (startAcc) begin
      rdBeat_d = '0;
      rdBlk_d  = '0;
    end else if (rdRun) begin
      rdBeat_d = rdBeat_q + BW'(1);
      if (rdLastBeat) begin
        rdBlk_d   = rdBlk_q + IW'(1);
        rdState_d = rdStart ? RD_RUN : RD_IDLE;
      end
    end else if (rdStart) begin
      rdState_d = RD_RUN;
    end
  end

  // Output stage: the buffer read takes one cycle, so valid_out and its tags
  // are the read-issue information delayed by one register.
  always_comb begin
    validOut_d  = rdRun;
    blkIdx_d    = rdRun ? rdBlk_q : '0;
    frameLast_d = rdLastBeat && (rdBlk_q == IW'(NUM_BLK-1));
    frameDone_d = frameLast_q;
  end

  // All state registers; reset discards any in-flight tokens and reads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rdState_q   <= RD_IDLE;
      wrBeat_q    <= '0;
      wrBlk_q     <= '0;
      magEn_q     <= 1'b0;
      wrAddr_q    <= '0;
      minEn_q     <= 1'b0;
      minClr_q    <= 1'b0;
      blkLast_q   <= 1'b0;
      tok_q       <= '0;
      pend_q      <= '0;
      rdBeat_q    <= '0;
      rdBlk_q     <= '0;
      validOut_q  <= 1'b0;
      blkIdx_q    <= '0;
      frameLast_q <= 1'b0;
      frameDone_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdState_q   <= rdState_d;
      wrBeat_q    <= wrBeat_d;
      wrBlk_q     <= wrBlk_d;
      magEn_q     <= magEn_d;
      wrAddr_q    <= wrAddr_d;
      minEn_q     <= minEn_d;
      minClr_q    <= minClr_d;
      blkLast_q   <= blkLast_d;
      tok_q       <= tok_d;
      pend_q      <= pend_d;
      rdBeat_q    <= rdBeat_d;
      rdBlk_q     <= rdBlk_d;
      validOut_q  <= validOut_d;
      blkIdx_q    <= blkIdx_d;
      frameLast_q <= frameLast_d;
      frameDone_q <= frameDone_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy_o        = (state_q == ST_RUN);
  assign mag_en_o      = magEn_q;
  assign buf_wr_en_o   = magEn_q;
  assign buf_wr_addr_o = wrAddr_q;
  assign min_en_o      = minEn_q;
  assign min_clr_o     = minClr_q;
  assign blk_last_o    = blkLast_q;
  assign buf_rd_en_o   = rdRun;
  assign shift_en_o    = rdRun;
  assign buf_rd_addr_o = {rdBlk_q[0], rdBeat_q};
  assign valid_out_o   = validOut_q;
  assign blk_idx_o     = blkIdx_q;
  assign frame_last_o  = frameLast_q;
  assign frame_done_o  = frameDone_q;
  assign ovf_err_o     = ovf_q;

endmodule

// File: tb/tb_cbfp_blk_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cbfp_blk_sequencer
// Testbench for cbfp_blk_sequencer. The main instance uses 4 beats/block,
// 2 blocks/frame and a read delay of 2. A second instance uses a read delay
// of 4 and 4 blocks/frame so that a buffer half gets rewritten while it is
// being read, and a small memory model checks that the data read back is
// the data that was written for that beat.
// ---------------------------------------------------------------------------
module tb_cbfp_blk_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start, dinValid, start4, dinValid4;

  logic busy, magEn, minEn, minClr, blkLast, wrEn, rdEn, shiftEn;
  logic vOut, fLast, fDone, ovf;
  logic [2:0] wrAddr, rdAddr;
  logic [1:0] blkIdx;

  logic busy4, magEn4, minEn4, minClr4, blkLast4, wrEn4, rdEn4, shiftEn4;
  logic vOut4, fLast4, fDone4, ovf4;
  logic [2:0] wrAddr4, rdAddr4;
  logic [2:0] blkIdx4;

  int nChecks;
  int nFails;

  typedef struct {
    logic start, din;
    logic busy, mag, minEn, minClr, blkLast, rdEn, vOut, fLast, fDone, ovf;
    logic [2:0] wrAddr, rdAddr;
    logic [1:0] blkIdx;
  } vec_t;

  vec_t tbl [0:31];

  cbfp_blk_sequencer #(.BEATS_PER_BLK(4), .NUM_BLK(2), .RD_DELAY(2)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .din_valid_i(dinValid),
    .busy_o(busy), .mag_en_o(magEn), .min_en_o(minEn), .min_clr_o(minClr),
    .blk_last_o(blkLast), .buf_wr_en_o(wrEn), .buf_wr_addr_o(wrAddr),
    .buf_rd_en_o(rdEn), .buf_rd_addr_o(rdAddr), .shift_en_o(shiftEn),
    .valid_out_o(vOut), .blk_idx_o(blkIdx), .frame_last_o(fLast),
    .frame_done_o(fDone), .ovf_err_o(ovf)
  );

  cbfp_blk_sequencer #(.BEATS_PER_BLK(4), .NUM_BLK(4), .RD_DELAY(4)) dut4 (
    .clk(clk), .rstn(rstn), .start_i(start4), .din_valid_i(dinValid4),
    .busy_o(busy4), .mag_en_o(magEn4), .min_en_o(minEn4), .min_clr_o(minClr4),
    .blk_last_o(blkLast4), .buf_wr_en_o(wrEn4), .buf_wr_addr_o(wrAddr4),
    .buf_rd_en_o(rdEn4), .buf_rd_addr_o(rdAddr4), .shift_en_o(shiftEn4),
    .valid_out_o(vOut4), .blk_idx_o(blkIdx4), .frame_last_o(fLast4),
    .frame_done_o(fDone4), .ovf_err_o(ovf4)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net in case a wait ever runs away
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] packExp(vec_t v);
    return {12'b0, v.busy, v.mag, v.mag, v.minEn, v.minClr, v.blkLast, v.rdEn, v.rdEn,
            v.vOut, v.fLast, v.fDone, v.ovf, v.wrAddr, v.rdAddr, v.blkIdx};
  endfunction

  function automatic logic [31:0] sampleDut();
    return {12'b0, busy, magEn, wrEn, minEn, minClr, blkLast, rdEn, shiftEn,
            vOut, fLast, fDone, ovf, magEn ? wrAddr : 3'b0, rdEn ? rdAddr : 3'b0,
            vOut ? blkIdx : 2'b0};
  endfunction

  function automatic logic [31:0] sampleRaw();
    return {12'b0, busy, magEn, wrEn, minEn, minClr, blkLast, rdEn, shiftEn,
            vOut, fLast, fDone, ovf, wrAddr, rdAddr, blkIdx};
  endfunction

  function automatic logic [31:0] sampleRaw4();
    return {11'b0, busy4, magEn4, wrEn4, minEn4, minClr4, blkLast4, rdEn4, shiftEn4,
            vOut4, fLast4, fDone4, ovf4, wrAddr4, rdAddr4, blkIdx4};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the
  // falling edge so the caller samples settled outputs of that cycle.
  task automatic applyStimulus(input logic s, input logic d, input logic s4, input logic d4);
    @(posedge clk);
    #1;
    start     = s;
    dinValid  = d;
    start4    = s4;
    dinValid4 = d4;
    @(negedge clk);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    start = 1'b0; dinValid = 1'b0; start4 = 1'b0; dinValid4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clearTable();
    for (int i = 0; i < 32; i++) tbl[i] = '{default: '0};
  endtask

  task automatic runTable(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus(tbl[c].start, tbl[c].din, 1'b0, 1'b0);
      checkOutput($sformatf("%s cyc%0d", tag, c), sampleDut(), packExp(tbl[c]));
    end
  endtask

  // start@0, contiguous beats 1..8; an optional second start while busy
  task automatic buildContig(input int extraStart);
    clearTable();
    for (int c = 0; c < 19; c++) begin
      tbl[c].start   = (c == 0) || (c == extraStart);
      tbl[c].din     = (c >= 1) && (c <= 8);
      tbl[c].busy    = (c >= 1) && (c <= 17);
      tbl[c].mag     = (c >= 2) && (c <= 9);
      tbl[c].wrAddr  = tbl[c].mag ? 3'(c - 2) : 3'b0;
      tbl[c].minEn   = (c >= 3) && (c <= 10);
      tbl[c].minClr  = (c == 3) || (c == 7);
      tbl[c].blkLast = (c == 6) || (c == 10);
      tbl[c].rdEn    = (c >= 8) && (c <= 15);
      tbl[c].rdAddr  = tbl[c].rdEn ? 3'(c - 8) : 3'b0;
      tbl[c].vOut    = (c >= 9) && (c <= 16);
      tbl[c].blkIdx  = tbl[c].vOut ? 2'((c - 9) / 4) : 2'b0;
      tbl[c].fLast   = (c == 16);
      tbl[c].fDone   = (c == 17);
    end
  endtask

  // start@0, beats on cycles 1,3,5,...,15
  task automatic buildAlternate();
    clearTable();
    tbl[0].start = 1'b1;
    for (int c = 1; c <= 24; c++) tbl[c].busy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tbl[1 + 2*k].din    = 1'b1;
      tbl[2 + 2*k].mag    = 1'b1;
      tbl[2 + 2*k].wrAddr = 3'(k);
      tbl[3 + 2*k].minEn  = 1'b1;
      if (k % 4 == 0) tbl[3 + 2*k].minClr  = 1'b1;
      if (k % 4 == 3) tbl[3 + 2*k].blkLast = 1'b1;
    end
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        tbl[11 + 8*b + j].rdEn   = 1'b1;
        tbl[11 + 8*b + j].rdAddr = 3'(4*b + j);
        tbl[12 + 8*b + j].vOut   = 1'b1;
        tbl[12 + 8*b + j].blkIdx = 2'(b);
      end
    end
    tbl[23].fLast = 1'b1;
    tbl[24].fDone = 1'b1;
  endtask

  // Long read delay, 4 blocks: reads must be gapless and return old data
  // when a half is rewritten in the same cycle it is read.
  task automatic runDelay4();
    int mem [0:7];
    int wrSeq, rdSeq;
    logic expBusy, expRd, expV, expFl, expFd;
    logic [2:0] expIdx;
    wrSeq = 0;
    rdSeq = 0;
    for (int i = 0; i < 8; i++) mem[i] = -1;
    checkOutput("d4 reset", sampleRaw4(), 32'b0);
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 1'b0, c == 0, (c >= 1) && (c <= 16));
      expBusy = (c >= 1) && (c <= 27);
      expRd   = (c >= 10) && (c <= 25);
      expV    = (c >= 11) && (c <= 26);
      expFl   = (c == 26);
      expFd   = (c == 27);
      expIdx  = expV ? 3'((c - 11) / 4) : 3'b0;
      checkOutput($sformatf("d4 cyc%0d", c),
                  {23'b0, busy4, rdEn4, shiftEn4, vOut4, fLast4, fDone4, vOut4 ? blkIdx4 : 3'b0},
                  {23'b0, expBusy, expRd, expRd, expV, expFl, expFd, expIdx});
      if (rdEn4) begin
        checkOutput($sformatf("d4 data rd%0d", rdSeq), 32'(mem[rdAddr4]), 32'(rdSeq));
        rdSeq++;
      end
      if (wrEn4) begin
        mem[wrAddr4] = wrSeq;
        wrSeq++;
      end
    end
    checkOutput("d4 read count", 32'(rdSeq), 32'd16);
  endtask

  // Beats outside an accepting frame: before start and a 9th beat
  task automatic runOverflow();
    int n;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf reset {mag,ovf}", {30'b0, magEn, ovf}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf pre-start {mag,ovf}", {30'b0, magEn, ovf}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf held {busy,ovf}", {30'b0, busy, ovf}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 0) checkOutput("ovf cleared {busy,ovf}", {30'b0, busy, ovf}, 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf beat8 {mag,addr,ovf}", {27'b0, magEn, wrAddr, ovf}, {27'b0, 1'b1, 3'd7, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf beat9 {mag,ovf}", {30'b0, magEn, ovf}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("ovf frame end {busy,ovf}", {30'b0, busy, ovf}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf restart {busy,ovf}", {30'b0, busy, ovf}, 32'd2);
  endtask

  // Reset asserted while block 0 is being read, then a clean frame
  task automatic runMidReset();
    buildContig(-1);
    runTable("preReset", 11);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    start = 1'b0;
    dinValid = 1'b0;
    #1;
    checkOutput("async reset", sampleRaw(), 32'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset next cycle", sampleRaw(), 32'b0);
    rstn = 1'b1;
    runTable("postReset", 19);
  endtask

  // Main sequence
  initial begin
    nChecks = 0;
    nFails  = 0;
    $display("[TB] cbfp_blk_sequencer test start");

    doReset();
    buildContig(-1);
    runTable("contig", 19);

    doReset();
    buildAlternate();
    runTable("alt", 26);

    doReset();
    runDelay4();

    doReset();
    runOverflow();

    doReset();
    buildContig(5);
    runTable("busyStart", 19);

    doReset();
    runMidReset();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
